// File: rtl/simon_pkg.sv
// -----------------------------------------------------------------------------
// simon_pkg
// Shared definitions for the Simon round controller and its round counter:
//   - state_t   : FSM state encoding (3 bits, codes 6/7 unused)
//   - MODE_*    : operation direction as latched by the controller
//   - *_ROUNDS  : default round count for each Simon block/key variant
//   - sat_value : value at which the round counter stops counting
// No ports (package).
// -----------------------------------------------------------------------------
package simon_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_KEY_GEN = 3'd1,
    ST_LOAD    = 3'd2,
    ST_ENC     = 3'd3,
    ST_DEC     = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  // Round counts of the standard Simon variants (block/key size).
  localparam int SIMON32_64_ROUNDS   = 32;
  localparam int SIMON48_96_ROUNDS   = 36;
  localparam int SIMON64_128_ROUNDS  = 44;
  localparam int SIMON96_144_ROUNDS  = 54;
  localparam int SIMON128_256_ROUNDS = 72;

  // The counter finishes an operation holding ROUNDS. When ROUNDS equals
  // 2**cnt_w that value is not representable, so the counter parks at the
  // all-ones value instead of wrapping back to zero.
  function automatic int sat_value(input int rounds, input int cnt_w);
    int full;
    full = (1 << cnt_w);
    if (rounds >= full)
      return full - 1;
    else
      return rounds;
  endfunction

endpackage

// File: rtl/simon_round_counter.sv
// -----------------------------------------------------------------------------
// simon_round_counter
// Round counter for the Simon controller. Counts completed rounds, saturates
// once the last round has been counted and produces the round-key read
// address for either direction.
// Ports:
//   clk      in            system clock, rising edge
//   res      in            asynchronous active-high reset
//   clr      in            synchronous clear to zero (higher priority than en)
//   en       in            count one round
//   dir      in            0 = ascending key order, 1 = descending key order
//   cnt      out [CNT_W]   rounds completed
//   tc       out           terminal count: the current round is the last one
//   key_addr out [CNT_W]   round-key address (cnt, or ROUNDS-1-cnt mod 2**CNT_W)
// -----------------------------------------------------------------------------
module simon_round_counter
  import simon_pkg::*;
#(
  parameter int CNT_W  = 5,
  parameter int ROUNDS = SIMON32_64_ROUNDS
) (
  input  logic             clk,
  input  logic             res,
  input  logic             clr,
  input  logic             en,
  input  logic             dir,
  output logic [CNT_W-1:0] cnt,
  output logic             tc,
  output logic [CNT_W-1:0] key_addr
);

  localparam logic [CNT_W-1:0] LAST_VAL = CNT_W'(ROUNDS - 1);
  localparam logic [CNT_W-1:0] SAT_VAL  = CNT_W'(sat_value(ROUNDS, CNT_W));

  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;

  always_comb begin
    cnt_next = cnt_reg;
    if (clr)
      cnt_next = '0;
    else if (en && (cnt_reg != SAT_VAL))
      cnt_next = cnt_reg + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge res) begin
    if (res)
      cnt_reg <= '0;
    else
      cnt_reg <= cnt_next;
  end

  assign cnt = cnt_reg;
  assign tc  = (cnt_reg == LAST_VAL);

  // Descending order is a plain modular subtraction; with ROUNDS = 2**CNT_W
  // LAST_VAL is all ones and the result still covers ROUNDS-1 .. 0 exactly.
  assign key_addr = dir ? (LAST_VAL - cnt_reg) : cnt_reg;

endmodule

// File: rtl/simon_round_ctrl.sv
// -----------------------------------------------------------------------------
// simon_round_ctrl
// Control FSM for the Simon cipher datapath. Starts the key schedule, loads
// the input block, issues ROUNDS round enables with the matching round-key
// address and holds the result until the consumer acknowledges it.
// Encryption starts loading immediately (keys are consumed in the order the
// schedule produces them); decryption needs the last key first, so it waits
// in KEY_GEN for the whole schedule to complete.
// Ports:
//   clk           in            system clock, rising edge
//   res           in            asynchronous active-high reset
//   start         in            request an operation (sampled in IDLE only)
//   mode          in            0 = encrypt, 1 = decrypt (sampled with start)
//   abort         in            cancel the running operation
//   key_done      in            key schedule finished (used in KEY_GEN only)
//   out_ack       in            consumer took the result (used in DONE)
//   state         out [3]       current FSM state
//   mode_q        out           mode latched at start
//   key_gen_start out           one-cycle pulse starting the key schedule
//   load_in       out           load the input block into the datapath
//   round_en      out           advance the datapath by one round
//   key_addr      out [CNT_W]   round-key read address
//   round_cnt     out [CNT_W]   rounds completed in this operation
//   busy          out           operation in progress
//   done          out           result valid
// All outputs are decoded from registers only.
// -----------------------------------------------------------------------------
module simon_round_ctrl
  import simon_pkg::*;
#(
  parameter int ROUNDS = SIMON32_64_ROUNDS,
  parameter int CNT_W  = 5
) (
  input  logic             clk,
  input  logic             res,
  input  logic             start,
  input  logic             mode,
  input  logic             abort,
  input  logic             key_done,
  input  logic             out_ack,
  output logic [2:0]       state,
  output logic             mode_q,
  output logic             key_gen_start,
  output logic             load_in,
  output logic             round_en,
  output logic [CNT_W-1:0] key_addr,
  output logic [CNT_W-1:0] round_cnt,
  output logic             busy,
  output logic             done
);

  state_t state_reg;
  state_t state_next;
  logic   mode_q_reg;
  logic   mode_q_next;
  logic   kgs_reg;
  logic   kgs_next;
  logic   cnt_clr;
  logic   cnt_en;
  logic   cnt_tc;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next  = state_reg;
    mode_q_next = mode_q_reg;
    kgs_next    = 1'b0;
    cnt_clr     = 1'b0;
    cnt_en      = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        // abort is meaningless here, so start is honoured regardless of it.
        if (start) begin
          mode_q_next = mode;
          kgs_next    = 1'b1;
          state_next  = (mode == MODE_DEC) ? ST_KEY_GEN : ST_LOAD;
        end
      end
      ST_KEY_GEN: begin
        if (key_done)
          state_next = ST_LOAD;
      end
      ST_LOAD: begin
        cnt_clr    = 1'b1;
        state_next = (mode_q_reg == MODE_DEC) ? ST_DEC : ST_ENC;
      end
      ST_ENC, ST_DEC: begin
        cnt_en = 1'b1;
        if (cnt_tc)
          state_next = ST_DONE;
      end
      ST_DONE: begin
        // A start seen here is dropped; the host re-issues it from IDLE.
        if (out_ack)
          state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // Abort overrides every other transition of an active operation.
    if (abort && (state_reg != ST_IDLE)) begin
      state_next = ST_IDLE;
      cnt_clr    = 1'b1;
      cnt_en     = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_reg  <= ST_IDLE;
      mode_q_reg <= MODE_ENC;
      kgs_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      mode_q_reg <= mode_q_next;
      kgs_reg    <= kgs_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Round counter / key address
  // ---------------------------------------------------------------------------
  simon_round_counter #(
    .CNT_W  (CNT_W),
    .ROUNDS (ROUNDS)
  ) u_counter (
    .clk      (clk),
    .res      (res),
    .clr      (cnt_clr),
    .en       (cnt_en),
    .dir      (mode_q_reg),
    .cnt      (round_cnt),
    .tc       (cnt_tc),
    .key_addr (key_addr)
  );

  // ---------------------------------------------------------------------------
  // Moore output decode
  // ---------------------------------------------------------------------------
  assign state         = state_reg;
  assign mode_q        = mode_q_reg;
  assign key_gen_start = kgs_reg;
  assign load_in       = (state_reg == ST_LOAD);
  assign round_en      = (state_reg == ST_ENC) || (state_reg == ST_DEC);
  assign busy          = (state_reg == ST_KEY_GEN) || (state_reg == ST_LOAD) ||
                         (state_reg == ST_ENC)     || (state_reg == ST_DEC);
  assign done          = (state_reg == ST_DONE);

endmodule
